// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single FIFO write port among N requesters. Arbitration is round-robin
//   with bounded bursts: the owner may write up to MAX_BURST words, then ownership
//   rotates. Each ownership is followed by exactly one IDLE cycle of arbitration.
//
// Ports:
//   clk       FIFO write-side clock
//   rst       asynchronous active-low reset
//   req       per-requester write request (data valid while high)
//   req_data  packed requester data, slice i = [i*W +: W]
//   gnt       one-hot accept strobe, word of requester i consumed this cycle
//   full      FIFO full flag
//   write     FIFO write enable
//   wdata     FIFO write data (0 while idle)
//   owner     current / last owner index
//   busy      high while a requester owns the port
//
// Optional feature (macro WARB_WORDCNT_EN):
//   cnt_clr   synchronous clear of word_cnt, wins over a coincident write
//   word_cnt  16-bit wrapping count of FIFO writes
module fifo_wr_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         gnt,
    input  logic                 full,
    output logic                 write,
    output logic [W-1:0]         wdata,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
`ifdef WARB_WORDCNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [15:0]          word_cnt
`endif
);

    localparam int unsigned OW = $clog2(N);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    localparam logic [7:0] BurstLast = 8'(MAX_BURST - 1);

    logic [0:0]    state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]    burst_q, burst_d;

    logic [OW-1:0] pick;
    logic [OW-1:0] idx;
    logic          found;
    logic [OW-1:0] owner_nxt;
    logic [W-1:0]  owner_data;

    // First requester at or above rr_ptr, wrapping N-1 -> 0.
    always_comb begin
        pick  = rr_ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = OW'((32'(rr_ptr_q) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == OW'(i)) begin
                owner_data = req_data[i*W +: W];
            end
        end
    end

    assign owner_nxt = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        write    = 1'b0;
        gnt      = '0;
        wdata    = '0;
        if (state_q == StIdle) begin
            if (|req) begin
                owner_d = pick;
                burst_d = '0;
                state_d = StBusy;
            end
        end else begin
            // full only stalls; ownership and burst count are held.
            write = req[owner_q] & ~full;
            wdata = owner_data;
            if (write) begin
                gnt[owner_q] = 1'b1;
                burst_d      = burst_q + 8'd1;
            end
            if (write && (burst_q == BurstLast)) begin
                rr_ptr_d = owner_nxt;
                state_d  = StIdle;
            end else if (!req[owner_q]) begin
                rr_ptr_d = owner_nxt;
                state_d  = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    assign owner = owner_q;
    assign busy  = (state_q == StBusy);

`ifdef WARB_WORDCNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q <= '0;
        end else if (cnt_clr) begin
            word_cnt_q <= '0;
        end else if (write) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule
